// File: rtl/esc_pkg.sv
// Shared encodings for the ESC drive path: sequencer states, fault codes and hall legality.
package esc_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_STOP_RAMP = 3'd2,
        S_COAST     = 3'd3,
        S_BRAKE     = 3'd4,
        S_FAULT     = 3'd5
    } esc_state_e;

    localparam logic [1:0] FLT_NONE  = 2'd0;
    localparam logic [1:0] FLT_HALL  = 2'd1;
    localparam logic [1:0] FLT_STALL = 2'd2;

    // All-low and all-high hall codes cannot occur on a healthy 120-degree sensor set.
    localparam logic [2:0] HALL_ALL_LOW  = 3'b000;
    localparam logic [2:0] HALL_ALL_HIGH = 3'b111;

    function automatic logic hall_legal(input logic [2:0] code);
        return (code != HALL_ALL_LOW) && (code != HALL_ALL_HIGH);
    endfunction

endpackage

// File: rtl/esc_drive_sequencer_if.sv
// Operator request / commutator control bundle of the drive sequencer.
interface esc_drive_sequencer_if #(
    parameter int unsigned PWM_BITS = 12
);
    logic                enable_req;
    logic [PWM_BITS-1:0] duty_target;
    logic                dir_req;
    logic                brake_req;
    logic                clear_fault;
    logic                hall_1;
    logic                hall_2;
    logic                hall_3;
    logic                run_en;
    logic [PWM_BITS-1:0] duty;
    logic                dir;
    logic                brake;
    logic                coast;
    logic [2:0]          state;
    logic                fault;
    logic [1:0]          fault_code;

    modport master (
        output enable_req, duty_target, dir_req, brake_req, clear_fault,
        output hall_1, hall_2, hall_3,
        input  run_en, duty, dir, brake, coast, state, fault, fault_code
    );

    modport slave (
        input  enable_req, duty_target, dir_req, brake_req, clear_fault,
        input  hall_1, hall_2, hall_3,
        output run_en, duty, dir, brake, coast, state, fault, fault_code
    );
endinterface

// File: rtl/esc_duty_ramp.sv
// Slew-limited duty generator: a prescaler paces steps of at most RAMP_STEP toward target_i.
module esc_duty_ramp #(
    parameter int unsigned PWM_BITS  = 12,
    parameter int unsigned RAMP_DIV  = 1000,
    parameter int unsigned RAMP_STEP = 16
) (
    input  logic                clk_ctrl,
    input  logic                rst_ctrl,
    input  logic                load_zero_i,  // force duty and prescaler to zero
    input  logic                restart_i,    // restart the prescaler, hold duty
    input  logic [PWM_BITS-1:0] target_i,
    output logic [PWM_BITS-1:0] duty_o
);
    localparam int unsigned PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned EXT_W = PWM_BITS + 1;
    localparam logic [EXT_W-1:0] STEP_EXT = EXT_W'(RAMP_STEP);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [EXT_W-1:0]    cur_ext, tgt_ext, gap, step, stepped;
    logic                tick;

    assign tick = (pre_q == PRE_LAST);

    // One saturating step toward the target; the extra bit keeps the gap from wrapping.
    always_comb begin
        cur_ext = {1'b0, duty_q};
        tgt_ext = {1'b0, target_i};
        gap     = (tgt_ext > cur_ext) ? (tgt_ext - cur_ext) : (cur_ext - tgt_ext);
        step    = (gap > STEP_EXT) ? STEP_EXT : gap;
        stepped = (tgt_ext > cur_ext) ? (cur_ext + step) : (cur_ext - step);
    end

    // Prescaler advance and duty update on each tick.
    always_comb begin
        pre_d  = pre_q;
        duty_d = duty_q;
        if (load_zero_i) begin
            pre_d  = '0;
            duty_d = '0;
        end else if (restart_i) begin
            pre_d = '0;
        end else if (tick) begin
            pre_d  = '0;
            duty_d = stepped[PWM_BITS-1:0];
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Ramp state registers.
    always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            pre_q  <= '0;
            duty_q <= '0;
        end else begin
            pre_q  <= pre_d;
            duty_q <= duty_d;
        end
    end

    assign duty_o = duty_q;
endmodule

// File: rtl/esc_drive_sequencer.sv
// Supervisory sequencer for the six-step commutator: ramps, safe reversal, stop modes, hall faults.
module esc_drive_sequencer
    import esc_pkg::*;
#(
    parameter int unsigned PWM_BITS       = 12,
    parameter int unsigned RAMP_DIV       = 1000,
    parameter int unsigned RAMP_STEP      = 16,
    parameter int unsigned COAST_CYCLES   = 100000,
    parameter int unsigned BRAKE_CYCLES   = 200000,
    parameter int unsigned STALL_CYCLES   = 10000000,
    parameter int unsigned STALL_MIN_DUTY = 256,
    parameter int unsigned HALL_BAD_MAX   = 4
) (
    input logic                  clk_ctrl,
    input logic                  rst_ctrl,
    esc_drive_sequencer_if.slave bus
);
    localparam int unsigned DWELL_MAX = (COAST_CYCLES > BRAKE_CYCLES) ? COAST_CYCLES : BRAKE_CYCLES;
    localparam int unsigned DWELL_W   = $clog2(DWELL_MAX + 1);
    localparam int unsigned STALL_W   = $clog2(STALL_CYCLES + 1);
    localparam int unsigned BAD_W     = $clog2(HALL_BAD_MAX + 1);
    localparam logic [DWELL_W-1:0]  BRAKE_LAST = DWELL_W'(BRAKE_CYCLES - 1);
    localparam logic [DWELL_W-1:0]  COAST_LAST = DWELL_W'(COAST_CYCLES - 1);
    localparam logic [STALL_W-1:0]  STALL_TRIP = STALL_W'(STALL_CYCLES);
    localparam logic [BAD_W-1:0]    BAD_LAST   = BAD_W'(HALL_BAD_MAX - 1);
    localparam logic [PWM_BITS-1:0] MIN_DUTY   = PWM_BITS'(STALL_MIN_DUTY);

    (* ASYNC_REG = "TRUE" *) logic [2:0] hall_meta_q;
    (* ASYNC_REG = "TRUE" *) logic [2:0] hall_sync_q;
    logic [2:0]          hall_prev_q;
    esc_state_e          state_q, state_d;
    logic                dir_q, dir_d, run_en_q, run_en_d, brake_q, brake_d, coast_q, coast_d;
    logic                fault_q, fault_d;
    logic [1:0]          fault_code_q, fault_code_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [BAD_W-1:0]    bad_cnt_q, bad_cnt_d;
    logic [PWM_BITS-1:0] duty, ramp_target;
    logic                driving, hall_bad, hall_trip, stall_trip, ramp_zero, ramp_restart;

    // Hall synchroniser plus delayed copy for edge detection.
    always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            hall_meta_q <= '0;
            hall_sync_q <= '0;
            hall_prev_q <= '0;
        end else begin
            hall_meta_q <= {bus.hall_3, bus.hall_2, bus.hall_1};
            hall_sync_q <= hall_meta_q;
            hall_prev_q <= hall_sync_q;
        end
    end

    // Fault monitors, live only while the bridge is being driven.
    always_comb begin
        driving     = (state_q == S_RUN) || (state_q == S_STOP_RAMP);
        hall_bad    = !hall_legal(hall_sync_q);
        bad_cnt_d   = (driving && hall_bad) ? bad_cnt_q + 1'b1 : '0;
        stall_cnt_d = (driving && (hall_sync_q == hall_prev_q) && (duty >= MIN_DUTY)) ?
                      stall_cnt_q + 1'b1 : '0;
        hall_trip   = driving && hall_bad && (bad_cnt_q == BAD_LAST);
        stall_trip  = driving && (stall_cnt_d == STALL_TRIP);
    end

    // Next-state, fault latch and registered output decode.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        case (state_q)
            S_IDLE: begin
                if (bus.enable_req) begin
                    state_d = S_RUN;
                    dir_d   = bus.dir_req;
                end
            end
            S_RUN: begin
                if (!bus.enable_req || (bus.dir_req != dir_q)) state_d = S_STOP_RAMP;
            end
            S_STOP_RAMP: begin
                if (bus.enable_req && (bus.dir_req == dir_q)) state_d = S_RUN;
                else if (duty == '0) state_d = bus.brake_req ? S_BRAKE : S_COAST;
            end
            S_BRAKE: if (dwell_q == BRAKE_LAST) state_d = S_COAST;
            S_COAST: if (dwell_q == COAST_LAST) state_d = S_IDLE;
            S_FAULT: begin
                if (bus.clear_fault && !bus.enable_req) begin
                    state_d      = S_IDLE;
                    fault_d      = 1'b0;
                    fault_code_d = FLT_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A fault overrides whatever transition was chosen above.
        if (hall_trip || stall_trip) begin
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            fault_code_d = hall_trip ? FLT_HALL : FLT_STALL;
        end
        dwell_d  = ((state_d == state_q) && ((state_q == S_BRAKE) || (state_q == S_COAST))) ?
                   dwell_q + 1'b1 : '0;
        run_en_d = state_d inside {S_RUN, S_STOP_RAMP, S_BRAKE};
        brake_d  = (state_d == S_BRAKE);
        coast_d  = state_d inside {S_IDLE, S_COAST, S_FAULT};
        // Ramp follows the upcoming state so duty is already zero when the bridge goes idle.
        ramp_zero    = !(state_d inside {S_RUN, S_STOP_RAMP});
        ramp_restart = (state_d != state_q);
        ramp_target  = (state_d == S_RUN) ? bus.duty_target : '0;
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            state_q      <= S_IDLE;
            dir_q        <= 1'b0;
            run_en_q     <= 1'b0;
            brake_q      <= 1'b0;
            coast_q      <= 1'b1;
            fault_q      <= 1'b0;
            fault_code_q <= FLT_NONE;
            dwell_q      <= '0;
            stall_cnt_q  <= '0;
            bad_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            run_en_q     <= run_en_d;
            brake_q      <= brake_d;
            coast_q      <= coast_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            dwell_q      <= dwell_d;
            stall_cnt_q  <= stall_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
        end
    end

    esc_duty_ramp #(
        .PWM_BITS (PWM_BITS),
        .RAMP_DIV (RAMP_DIV),
        .RAMP_STEP(RAMP_STEP)
    ) u_ramp (
        .clk_ctrl   (clk_ctrl),
        .rst_ctrl   (rst_ctrl),
        .load_zero_i(ramp_zero),
        .restart_i  (ramp_restart),
        .target_i   (ramp_target),
        .duty_o     (duty)
    );

    assign bus.run_en     = run_en_q;
    assign bus.duty       = duty;
    assign bus.dir        = dir_q;
    assign bus.brake      = brake_q;
    assign bus.coast      = coast_q;
    assign bus.state      = state_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;
endmodule

// File: tb/tb_esc_drive_sequencer.sv
// Bench for esc_drive_sequencer: directed scenarios plus a random phase, checked every cycle
// against a behavioural model of the sequencing rules.
module tb_esc_drive_sequencer;
    localparam int PWM_BITS       = 12;
    localparam int RAMP_DIV       = 4;
    localparam int RAMP_STEP      = 16;
    localparam int COAST_CYCLES   = 8;
    localparam int BRAKE_CYCLES   = 8;
    localparam int STALL_CYCLES   = 64;
    localparam int STALL_MIN_DUTY = 32;
    localparam int HALL_BAD_MAX   = 3;

    // Model: st uses 0 idle, 1 run, 2 stop ramp, 3 coast, 4 brake, 5 fault.
    typedef struct packed {
        int st; int duty; int dir; int pre; int dwell; int bad; int stall;
        int h1; int h2; int hp; int fault; int code;
    } mdl_t;

    logic       clk_ctrl = 1'b0;
    logic       rst_ctrl;
    logic [2:0] hall_drv;
    int         hall_mode;  // 0 rotate, 1 freeze, 2 stuck 111, 3 bad-bad-legal pattern
    int         hall_idx;
    int         hall_ctr;
    int         checks = 0;
    int         errors = 0;
    mdl_t       m;

    always #5 clk_ctrl = ~clk_ctrl;

    esc_drive_sequencer_if #(.PWM_BITS(PWM_BITS)) bus ();
    assign {bus.hall_3, bus.hall_2, bus.hall_1} = hall_drv;

    esc_drive_sequencer #(
        .PWM_BITS      (PWM_BITS),
        .RAMP_DIV      (RAMP_DIV),
        .RAMP_STEP     (RAMP_STEP),
        .COAST_CYCLES  (COAST_CYCLES),
        .BRAKE_CYCLES  (BRAKE_CYCLES),
        .STALL_CYCLES  (STALL_CYCLES),
        .STALL_MIN_DUTY(STALL_MIN_DUTY),
        .HALL_BAD_MAX  (HALL_BAD_MAX)
    ) dut (
        .clk_ctrl(clk_ctrl),
        .rst_ctrl(rst_ctrl),
        .bus     (bus)
    );

    function automatic logic [2:0] hall_seq(input int idx);
        case (idx)
            0: return 3'b001;
            1: return 3'b011;
            2: return 3'b010;
            3: return 3'b110;
            4: return 3'b100;
            default: return 3'b101;
        endcase
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic mdl_t model_next(input mdl_t m0, input logic en, input int tgt,
                                        input logic dr, input logic brk, input logic clr,
                                        input logic [2:0] hall);
        mdl_t n;
        int   nxt;
        int   t;
        bit   driving;
        bit   tick;
        n       = m0;
        driving = (m0.st == 1) || (m0.st == 2);
        n.h1    = int'(hall);
        n.h2    = m0.h1;
        n.hp    = m0.h2;
        n.bad   = (driving && (m0.h2 == 0 || m0.h2 == 7)) ? m0.bad + 1 : 0;
        n.stall = (driving && m0.h2 == m0.hp && m0.duty >= STALL_MIN_DUTY) ? m0.stall + 1 : 0;
        tick    = driving && ((m0.pre + 1) % RAMP_DIV == 0);
        nxt     = m0.st;
        case (m0.st)
            0: if (en) begin nxt = 1; n.dir = int'(dr); end
            1: if (!en || int'(dr) != m0.dir) nxt = 2;
            2: begin
                if (en && int'(dr) == m0.dir) nxt = 1;
                else if (m0.duty == 0) nxt = brk ? 4 : 3;
            end
            4: if (m0.dwell == BRAKE_CYCLES - 1) nxt = 3;
            3: if (m0.dwell == COAST_CYCLES - 1) nxt = 0;
            default: if (clr && !en) begin nxt = 0; n.fault = 0; n.code = 0; end
        endcase
        if (driving && n.bad >= HALL_BAD_MAX) begin
            nxt = 5; n.fault = 1; n.code = 1;
        end else if (driving && n.stall >= STALL_CYCLES) begin
            nxt = 5; n.fault = 1; n.code = 2;
        end
        if (nxt != 1 && nxt != 2) begin
            n.duty = 0;
            n.pre  = 0;
        end else if (nxt != m0.st) begin
            n.pre = 0;
        end else begin
            n.pre = (m0.pre + 1) % RAMP_DIV;
            if (tick) begin
                t = (nxt == 1) ? tgt : 0;
                if (t > m0.duty) n.duty = m0.duty + min2(RAMP_STEP, t - m0.duty);
                else n.duty = m0.duty - min2(RAMP_STEP, m0.duty - t);
            end
        end
        n.dwell = (nxt == m0.st) ? m0.dwell + 1 : 0;
        n.st    = nxt;
        return n;
    endfunction

    always @(posedge clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) m <= '0;
        else m <= model_next(m, bus.enable_req, int'(bus.duty_target), bus.dir_req,
                             bus.brake_req, bus.clear_fault, hall_drv);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic [21:0] obs;
        logic [21:0] exp;
        logic        e_run, e_brake, e_coast;
        e_run   = (m.st == 1 || m.st == 2 || m.st == 4);
        e_brake = (m.st == 4);
        e_coast = (m.st == 0 || m.st == 3 || m.st == 5);
        obs = {bus.state, bus.run_en, bus.dir, bus.brake, bus.coast, bus.fault, bus.fault_code,
               bus.duty};
        exp = {m.st[2:0], e_run, m.dir[0], e_brake, e_coast, m.fault[0], m.code[1:0],
               m.duty[PWM_BITS-1:0]};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL cycle t=%0t: observed st/run/dir/brk/cst/flt/code/duty=%h, expected %h",
                   $time, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_ctrl);
            check_cycle();
            hall_ctr++;
            case (hall_mode)
                0: begin
                    if (hall_ctr % 20 == 0) hall_idx = (hall_idx + 1) % 6;
                    hall_drv = hall_seq(hall_idx);
                end
                1: hall_drv = hall_seq(hall_idx);
                2: hall_drv = 3'b111;
                default: hall_drv = (hall_ctr % 3 == 0) ? hall_seq(hall_idx) : 3'b000;
            endcase
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int n = 0;
        while (int'(bus.state) != s && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(bus.state), 32'(s));
    endtask

    task automatic wait_duty(input int d, input int budget, input string tag);
        int n = 0;
        while (int'(bus.duty) != d && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(bus.duty), 32'(d));
    endtask

    initial begin
        int cnt;
        int min_duty;
        int r;
        rst_ctrl        = 1'b0;
        bus.enable_req  = 1'b0;
        bus.duty_target = '0;
        bus.dir_req     = 1'b0;
        bus.brake_req   = 1'b0;
        bus.clear_fault = 1'b0;
        hall_mode       = 0;
        hall_idx        = 0;
        hall_ctr        = 0;
        hall_drv        = hall_seq(0);
        #2 rst_ctrl = 1'b1;
        #1;
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_coast", 32'(bus.coast), 32'd1);
        chk("reset_run_en", 32'(bus.run_en), 32'd0);
        repeat (2) @(negedge clk_ctrl);
        rst_ctrl = 1'b0;
        step(3);

        // Start-up ramp to 40.
        bus.enable_req  = 1'b1;
        bus.duty_target = 12'd40;
        step(1);
        chk("start_state", 32'(bus.state), 32'd1);
        chk("start_run_en", 32'(bus.run_en), 32'd1);
        chk("start_coast", 32'(bus.coast), 32'd0);
        step(4);  chk("ramp_tick1", 32'(bus.duty), 32'd16);
        step(4);  chk("ramp_tick2", 32'(bus.duty), 32'd32);
        step(4);  chk("ramp_tick3", 32'(bus.duty), 32'd40);
        step(8);  chk("ramp_hold", 32'(bus.duty), 32'd40);

        // Reversal with braking stop.
        bus.dir_req   = 1'b1;
        bus.brake_req = 1'b1;
        step(1);  chk("rev_stop_state", 32'(bus.state), 32'd2);
        step(4);  chk("rev_down1", 32'(bus.duty), 32'd24);
        step(4);  chk("rev_down2", 32'(bus.duty), 32'd8);
        step(4);  chk("rev_down3", 32'(bus.duty), 32'd0);
        wait_state(4, 10, "enter_brake");
        cnt = 0;
        while (int'(bus.state) == 4 && cnt < 20) begin
            if (bus.brake) cnt++;
            step(1);
        end
        chk("brake_cycles", 32'(cnt), 32'd8);
        cnt = 0;
        while (int'(bus.state) == 3 && cnt < 20) begin
            if (bus.coast) cnt++;
            step(1);
        end
        chk("coast_cycles", 32'(cnt), 32'd8);
        wait_state(1, 5, "restart_run");
        chk("restart_dir", 32'(bus.dir), 32'd1);

        // Aborted reversal returns to RUN without dropping to zero.
        step(14);
        chk("rerun_duty", 32'(bus.duty), 32'd40);
        bus.dir_req = 1'b0;
        wait_duty(24, 20, "abort_at_24");
        bus.dir_req = 1'b1;
        step(1);
        chk("abort_back_run", 32'(bus.state), 32'd1);
        min_duty = 4095;
        for (int i = 0; i < 16; i++) begin
            if (int'(bus.duty) < min_duty) min_duty = int'(bus.duty);
            step(1);
        end
        chk("abort_no_dip", 32'(min_duty), 32'd24);
        chk("abort_final", 32'(bus.duty), 32'd40);

        // Illegal hall code.
        hall_mode = 2;
        wait_state(5, 12, "hall_fault_state");
        chk("hall_fault", 32'(bus.fault), 32'd1);
        chk("hall_fault_code", 32'(bus.fault_code), 32'd1);
        chk("hall_fault_coast", 32'(bus.coast), 32'd1);
        chk("hall_fault_duty", 32'(bus.duty), 32'd0);
        hall_mode       = 0;
        bus.clear_fault = 1'b1;
        step(5);
        chk("clear_ignored", 32'(bus.state), 32'd5);
        bus.enable_req = 1'b0;
        step(1);
        chk("clear_idle", 32'(bus.state), 32'd0);
        chk("clear_fault", 32'(bus.fault), 32'd0);
        chk("clear_code", 32'(bus.fault_code), 32'd0);
        bus.clear_fault = 1'b0;

        // Stall: frozen halls at duty 40 trip, at duty 16 do not.
        bus.dir_req    = 1'b0;
        bus.enable_req = 1'b1;
        wait_duty(40, 30, "stall_duty40");
        hall_mode = 1;
        wait_state(5, 120, "stall_fault_state");
        chk("stall_code", 32'(bus.fault_code), 32'd2);
        bus.enable_req  = 1'b0;
        bus.clear_fault = 1'b1;
        step(1);
        chk("stall_clear", 32'(bus.state), 32'd0);
        bus.clear_fault = 1'b0;
        bus.duty_target = 12'd16;
        bus.enable_req  = 1'b1;
        step(150);
        chk("low_duty_run", 32'(bus.state), 32'd1);
        chk("low_duty_nofault", 32'(bus.fault), 32'd0);
        chk("low_duty_value", 32'(bus.duty), 32'd16);

        // Reset mid-ramp.
        hall_mode      = 0;
        bus.enable_req = 1'b0;
        wait_state(0, 80, "back_idle");
        bus.dir_req     = 1'b1;
        bus.duty_target = 12'd40;
        bus.enable_req  = 1'b1;
        wait_duty(40, 40, "pre_reset_40");
        bus.enable_req = 1'b0;
        wait_duty(24, 20, "pre_reset_24");
        chk("pre_reset_dir", 32'(bus.dir), 32'd1);
        #2 rst_ctrl = 1'b1;
        #1;
        chk("arst_state", 32'(bus.state), 32'd0);
        chk("arst_duty", 32'(bus.duty), 32'd0);
        chk("arst_run_en", 32'(bus.run_en), 32'd0);
        chk("arst_dir", 32'(bus.dir), 32'd0);
        chk("arst_brake", 32'(bus.brake), 32'd0);
        chk("arst_coast", 32'(bus.coast), 32'd1);
        chk("arst_fault", 32'(bus.fault), 32'd0);
        @(negedge clk_ctrl);
        rst_ctrl = 1'b0;
        step(2);

        // Random operator and hall activity against the model.
        for (int k = 0; k < 80; k++) begin
            bus.enable_req = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) bus.dir_req = ~bus.dir_req;
            bus.brake_req   = 1'($urandom_range(0, 1));
            bus.duty_target = 12'($urandom_range(0, 120));
            bus.clear_fault = ($urandom_range(0, 2) == 0);
            r         = int'($urandom_range(0, 9));
            hall_mode = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
            step(int'($urandom_range(5, 60)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
